// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the rr_arbiter8 round-robin arbiter slice.
package rr_arbiter8_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/decoder3x8.sv
// Enabled 3-to-8 line decoder; output is all zeros while en is low.
module decoder3x8 (
    input  logic       en,
    input  logic       a2,
    input  logic       a1,
    input  logic       a0,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[{a2, a1, a0}] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with one-hot grant via decoder3x8.
// Optional grant watchdog enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_sel,
    output logic       gnt_valid,
    output logic [7:0] gnt,
    output logic       timeout
);

    state_t           state_q, state_nx;
    logic [SEL_W-1:0] sel_nx;
    logic [SEL_W-1:0] ptr_q, ptr_nx;
    logic [SEL_W-1:0] search_base;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;
    logic             release_now;
    logic             expire;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_cnt, cnt_nx;
    logic              tout_nx;
`endif

    if (MAX_HOLD < 1 || MAX_HOLD > (2 ** HOLD_W) - 1) begin : g_bad_max_hold
        $error("rr_arbiter8: MAX_HOLD must lie in 1 .. 2**HOLD_W-1");
    end

    // First set request at or after base, wrapping mod 8; MSB flags a hit.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [SEL_W-1:0]   base);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = base + SEL_W'(k);
            if (!res[SEL_W] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_nx = state_q;
        sel_nx   = gnt_sel;
        ptr_nx   = ptr_q;
        expire   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_nx   = hold_cnt;
        tout_nx  = 1'b0;
        expire   = (hold_cnt == HOLD_LAST);
`endif
        release_now = done || !req[gnt_sel] || expire;
        // On release the search starts just past the owner, so it ranks last.
        search_base = (state_q == BUSY) ? gnt_sel + 1'b1 : ptr_q;
        {win_found, win_idx} = rr_pick(req, search_base);

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_nx = BUSY;
                    sel_nx   = win_idx;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_nx = search_base;
                    if (win_found) begin
                        sel_nx = win_idx;
                    end else begin
                        state_nx = IDLE;
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_nx  = '0;
                    tout_nx = expire && !done && req[gnt_sel];
`endif
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_nx = hold_cnt + 1'b1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_sel <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_nx;
            gnt_sel <= sel_nx;
            ptr_q   <= ptr_nx;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= cnt_nx;
            timeout  <= tout_nx;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign gnt_valid = (state_q == BUSY);

    decoder3x8 u_dec (
        .en (gnt_valid),
        .a2 (gnt_sel[2]),
        .a1 (gnt_sel[1]),
        .a0 (gnt_sel[0]),
        .y  (gnt)
    );

endmodule
